// File: rtl/cipher_loader.sv
// cipher_loader: byte-serial framer that assembles an AES-128 key and data block for the cipher.
// Optional key retention is enabled by defining CIPHER_KEY_RETAIN_EN (adds the keep_key port).
module cipher_loader (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
`ifdef CIPHER_KEY_RETAIN_EN
  input  logic                  keep_key,
`endif
  output logic [0:3][0:3][7:0]  data,
  output logic [0:3][0:3][7:0]  key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    PRESENT   = 2'd2
  } stateT;

  stateT      state, stateNext, frameStart;
  logic [3:0] cnt, cntNext;
  logic       inReadyQ, inReadyNext;
  logic       errQ, errNext;
  logic       retainQ, retainNext;
  logic       accept, lastSlot, keepKey;

`ifdef CIPHER_KEY_RETAIN_EN
  assign keepKey = keep_key;
`else
  assign keepKey = 1'b0;
`endif

  assign accept     = in_valid && inReadyQ;
  assign lastSlot   = (cnt == 4'd15);
  // A framing error restarts at the data section only while a retained key is in force.
  assign frameStart = retainQ ? LOAD_DATA : LOAD_KEY;

  // NOTE: every output of a combinational block gets a default first, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    errNext    = 1'b0;
    retainNext = retainQ;
    case (state)
      LOAD_KEY: begin
        if (accept) begin
          if (in_last) begin
            errNext    = 1'b1;
            stateNext  = frameStart;
            cntNext    = 4'd0;
          end else begin
            cntNext = cnt + 4'd1;
            if (lastSlot) stateNext = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (accept) begin
          if (in_last != lastSlot) begin
            errNext    = 1'b1;
            stateNext  = frameStart;
            cntNext    = 4'd0;
          end else begin
            cntNext = cnt + 4'd1;
            if (lastSlot) stateNext = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          cntNext    = 4'd0;
          retainNext = keepKey;
          stateNext  = keepKey ? LOAD_DATA : LOAD_KEY;
        end
      end
      default: begin
        stateNext = LOAD_KEY;
        cntNext   = 4'd0;
      end
    endcase
  end

  // in_ready is registered from the next state so it never depends on in_valid combinationally.
  assign inReadyNext = (stateNext != PRESENT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the key/data arrays are reset like any other register because the consumer
  // can observe them directly and their reset value is defined as all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_KEY;
      cnt      <= 4'd0;
      inReadyQ <= 1'b0;
      errQ     <= 1'b0;
      retainQ  <= 1'b0;
      key      <= '0;
      data     <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      inReadyQ <= inReadyNext;
      errQ     <= errNext;
      retainQ  <= retainNext;
      if (accept && state == LOAD_KEY)  key[cnt[3:2]][cnt[1:0]]  <= in_data;
      if (accept && state == LOAD_DATA) data[cnt[3:2]][cnt[1:0]] <= in_data;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = (state == PRESENT);
  assign err       = errQ;

endmodule

// File: tb/tb_cipher_loader.sv
// Scoreboard bench for cipher_loader: driver pushes expected events, negedge monitor pops/compares.
// Retention scenarios run only when CIPHER_KEY_RETAIN_EN is defined.
module tb_cipher_loader;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic                 keep_key;
  logic [0:3][0:3][7:0] data;
  logic [0:3][0:3][7:0] key;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err;

  cipher_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
`ifdef CIPHER_KEY_RETAIN_EN
    .keep_key  (keep_key),
`endif
    .data      (data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           isErr;
    logic [127:0] k;
    logic [127:0] d;
  } sbEntryT;

  sbEntryT sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_ALT = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushBlock(input logic [127:0] k, input logic [127:0] d);
    sbEntryT e;
    e.isErr = 1'b0; e.k = k; e.d = d;
    sb.push_back(e);
  endtask

  task automatic pushErr();
    sbEntryT e;
    e.isErr = 1'b1; e.k = '0; e.d = '0;
    sb.push_back(e);
  endtask

  // Monitor: an output transfer or an err pulse consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (err || (out_valid && out_ready))) begin
      if (sb.size() == 0) begin
        check("unexpected output event", {err, out_valid}, 2'b00);
      end else begin
        sbEntryT e;
        e = sb.pop_front();
        check("event is err", err, e.isErr);
        if (!e.isErr) begin
          check("block key", key, e.k);
          check("block data", data, e.d);
        end
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready timeout", in_ready, 1'b1);
  endtask

  // Streams n bytes from the top of s; in_last is raised only on byte lastAt (-1: never).
  task automatic sendStream(input logic [255:0] s, input int n, input int lastAt, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        int g = $urandom_range(0, 3);
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      in_data  = s[255 - 8*i -: 8];
      in_last  = (i == lastAt);
      in_valid = 1'b1;
      waitReady();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid drop timeout", out_valid, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    keep_key = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset err", err, 1'b0);
    check("reset key", key, 128'h0);
    check("reset data", data, 128'h0);
    rst_n = 1'b1;
    #1 check("in_ready before first edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("in_ready after first edge", in_ready, 1'b1);

    // Nominal frame with explicit spot checks and latency.
    out_ready = 1'b0;
    pushBlock(KEY_B, PT_B);
    sendStream({KEY_B, PT_B}, 32, 31, 1'b0);
    check("out_valid after byte 31", out_valid, 1'b1);
    check("in_ready low in PRESENT", in_ready, 1'b0);
    check("key[0][0]", key[0][0], 8'h2b);
    check("key[3][3]", key[3][3], 8'h3c);
    check("data[1][0]", data[1][0], 8'h88);

    // Backpressure: bytes offered while presenting must not be consumed.
    for (int c = 0; c < 10; c++) begin
      in_data = 8'hee; in_last = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp in_ready", in_ready, 1'b0);
      check("bp out_valid", out_valid, 1'b1);
      check("bp key", key, KEY_B);
      check("bp data", data, PT_B);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    check("in_ready after transfer", in_ready, 1'b1);

    // Bubbles: same arrays as nominal.
    pushBlock(KEY_B, PT_B);
    sendStream({KEY_B, PT_B}, 32, 31, 1'b1);
    waitIdle();

    // Early in_last on byte 20.
    pushErr();
    sendStream({KEY_B, PT_B}, 21, 20, 1'b0);
    check("err after early last", err, 1'b1);
    check("no out_valid after early last", out_valid, 1'b0);
    @(posedge clk); #1;
    check("err is one pulse", err, 1'b0);
    pushBlock(KEY_B, PT_ALT);
    sendStream({KEY_B, PT_ALT}, 32, 31, 1'b0);
    waitIdle();

    // Missing in_last on byte 31.
    pushErr();
    sendStream({KEY_B, PT_B}, 32, -1, 1'b0);
    check("err after missing last", err, 1'b1);
    check("no out_valid after missing last", out_valid, 1'b0);
    pushBlock(KEY_B, PT_B);
    sendStream({KEY_B, PT_B}, 32, 31, 1'b0);
    waitIdle();

    // Reset mid-frame after byte 10.
    sendStream({PT_ALT, PT_ALT}, 11, -1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid reset in_ready", in_ready, 1'b0);
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset key", key, 128'h0);
    check("mid reset data", data, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pushBlock(KEY_B, PT_B);
    sendStream({KEY_B, PT_B}, 32, 31, 1'b0);
    waitIdle();

`ifdef CIPHER_KEY_RETAIN_EN
    // Retain key: 16-byte data-only frame follows.
    keep_key = 1'b1;
    pushBlock(KEY_B, PT_B);
    sendStream({KEY_B, PT_B}, 32, 31, 1'b0);
    @(posedge clk); #1;
    keep_key = 1'b0;
    pushBlock(KEY_B, PT_ALT);
    sendStream({PT_ALT, 128'h0}, 16, 15, 1'b0);
    check("retain out_valid after byte 15", out_valid, 1'b1);
    check("retain key kept", key, KEY_B);
    waitIdle();
    // keep_key=0 at that transfer: a 16-byte frame is now a framing error.
    pushErr();
    sendStream({PT_ALT, 128'h0}, 16, 15, 1'b0);
    check("retain off err", err, 1'b1);
    pushBlock(PT_ALT, PT_B);
    sendStream({PT_ALT, PT_B}, 32, 31, 1'b0);
    waitIdle();
`endif

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
